cut_bist_tester: RTL
====================

// Module: cut_bist_tester
// PURPOSE
//   Tester side of a combinational circuit-under-test (CUT) netlist: drives pseudo-random input
//   vectors into the CUT and compacts its responses into a MISR signature. Sits between the test
//   harness and a 12-in/4-out gate-level case circuit; the harness pulses start and reads pass/sig.
//   One vector is outstanding at a time; the CUT side (or its wrapper) acknowledges with resp_valid.
// PARAMETERS
//   IN_W       12       CUT input width = LFSR width
//   OUT_W      4        CUT output width = MISR width
//   LFSR_POLY  12'h829  Galois feedback mask (x^12+x^11+x^5+x^3+1 form, bit i = tap)
//   SEED       12'hACE  LFSR reset/start value; must be nonzero (0 is replaced by 1)
//   MISR_POLY  4'h9     MISR feedback mask
//   NUM_VEC    256      vectors per run, 1..2^IN_W-1
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      1-cycle pulse; begins a run from IDLE or DONE
//   golden_sig   in   OUT_W  expected signature, sampled when the run completes
//   vec_out      out  IN_W   vector to CUT inputs
//   vec_valid    out  1      vec_out is valid; held until resp_valid
//   resp_in      in   OUT_W  CUT outputs for vec_out
//   resp_valid   in   1      resp_in valid; acknowledges current vector
//   busy         out  1      run in progress
//   done         out  1      run complete; held until next start or rst
//   sig          out  OUT_W  current MISR signature
//   pass         out  1      sig == golden_sig at completion; valid only while done=1
// BEHAVIOUR
//   - Reset: state=IDLE, lfsr=SEED, sig=0, count=0; vec_out=SEED, vec_valid=0, busy=0, done=0, pass=0.
//   - States: IDLE -> (start) DRIVE -> (last ack) DONE -> (start) DRIVE. No other transitions.
//   - On start: lfsr<=SEED, sig<=0, count<=0, done<=0, pass<=0; DRIVE entered next cycle.
//   - DRIVE: vec_valid=1, busy=1, vec_out=lfsr (registered, stable until ack).
//   - Ack = DRIVE && resp_valid, same cycle as vec_valid: sig<=misr_next(sig,resp_in);
//     lfsr<=lfsr_next; count<=count+1; if count==NUM_VEC-1 -> DONE and pass<=(misr_next==golden_sig).
//   - Latency: vector k presented >=1 cycle after ack k-1; with resp_valid tied high, one vector/cycle,
//     done asserted NUM_VEC+1 cycles after start pulse.
//   - lfsr_next = {lfsr[IN_W-2:0],1'b0} ^ (lfsr[IN_W-1] ? LFSR_POLY : 0).
//   - misr_next = {sig[OUT_W-2:0],1'b0} ^ (sig[OUT_W-1] ? MISR_POLY : 0) ^ resp_in.
//   - count width $clog2(NUM_VEC+1); never wraps within a run.
//   - resp_valid outside DRIVE ignored (no sig/lfsr change). start during DRIVE ignored.
//   - start and resp_valid in same DRIVE cycle: ack processed, start dropped.
//   - rst has priority over everything, including mid-run: returns to reset values next cycle.
//   - DONE: vec_valid=0, busy=0, done=1; sig/pass frozen; vec_out holds last advanced lfsr.
// STRUCTURE
//   - Package cut_bist_pkg: state enum {IDLE,DRIVE,DONE}, default IN_W/OUT_W, LFSR_POLY, SEED, MISR_POLY.
//   - One sub-module: lfsr_galois (W, POLY params; parallel-in XOR term) instantiated twice:
//     as LFSR (data-in = 0) and as MISR (data-in = resp_in). FSM + counter in top.
// TESTING
//   - Reset then start, resp_valid tied 1: vec_out sequence 0xACE, 0xDB5, ...; done at cycle NUM_VEC+1.
//   - NUM_VEC=2, resp 0x5 then 0x3 from sig=0 -> sig 0x5 then 0x9; golden_sig=0x9 -> pass=1; 0x8 -> pass=0.
//   - Stalled CUT: resp_valid low 5 cycles in DRIVE -> vec_out/vec_valid stable, sig/count unchanged.
//   - Spurious resp_valid in IDLE and DONE, start during DRIVE -> no state/sig/count change.
//   - rst asserted mid-run (count=7) -> next cycle IDLE, sig=0, vec_out=0xACE, busy=0, done=0.
//   - Back-to-back runs: start in DONE restarts from SEED; identical responses give identical sig.

Source files
------------

// File: rtl/cut_bist_tester_pkg.sv
// Shared types and default parameters for the CUT BIST tester.
package cut_bist_pkg;

    localparam int             DEF_IN_W      = 12;
    localparam int             DEF_OUT_W     = 4;
    localparam logic [11:0]    DEF_LFSR_POLY = 12'h829;
    localparam logic [11:0]    DEF_SEED      = 12'hACE;
    localparam logic [3:0]     DEF_MISR_POLY = 4'h9;
    localparam int             DEF_NUM_VEC   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/cut_bist_tester_if.sv
// Vector/response handshake between the tester and the circuit under test.
interface cut_bist_tester_if #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 4
);
    logic [IN_W-1:0]  vec_out;
    logic             vec_valid;
    logic [OUT_W-1:0] resp_in;
    logic             resp_valid;

    // Tester side: presents vectors, receives responses.
    modport master (
        output vec_out,
        output vec_valid,
        input  resp_in,
        input  resp_valid
    );

    // CUT side (or its wrapper): consumes vectors, returns responses.
    modport slave (
        input  vec_out,
        input  vec_valid,
        output resp_in,
        output resp_valid
    );
endinterface

// File: rtl/cut_bist_tester_lfsr.sv
// Galois shift-register next-state function with a parallel XOR input.
// With din tied to zero it is a plain LFSR step; with din = CUT response
// it is one MISR compaction step.
module lfsr_galois #(
    parameter int           W    = 12,
    parameter logic [W-1:0] POLY = '1
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] din,
    output logic [W-1:0] nxt
);

    // Shift left, fold the outgoing MSB back through the tap mask, absorb din.
    always_comb begin
        nxt = {cur[W-2:0], 1'b0} ^ (cur[W-1] ? POLY : '0) ^ din;
    end

endmodule

// File: rtl/cut_bist_tester.sv
// Tester for a combinational CUT: walks an LFSR through NUM_VEC vectors,
// one outstanding at a time, and compacts the responses into a MISR.
module cut_bist_tester
    import cut_bist_pkg::*;
#(
    parameter int               IN_W      = DEF_IN_W,
    parameter int               OUT_W     = DEF_OUT_W,
    parameter logic [IN_W-1:0]  LFSR_POLY = DEF_LFSR_POLY,
    parameter logic [IN_W-1:0]  SEED      = DEF_SEED,
    parameter logic [OUT_W-1:0] MISR_POLY = DEF_MISR_POLY,
    parameter int               NUM_VEC   = DEF_NUM_VEC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [OUT_W-1:0]   golden_sig,
    cut_bist_tester_if.master  cut,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   sig,
    output logic               pass
);

    // An all-zero seed would lock the LFSR at zero, so it is forced to 1.
    localparam logic [IN_W-1:0]  SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;
    localparam int               CNT_W    = $clog2(NUM_VEC + 1);
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(NUM_VEC - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [IN_W-1:0]  lfsr_q;
    logic [IN_W-1:0]  lfsr_next;
    logic [OUT_W-1:0] misr_next;
    logic             vec_valid_q;

    lfsr_galois #(
        .W    (IN_W),
        .POLY (LFSR_POLY)
    ) u_lfsr (
        .cur (lfsr_q),
        .din ('0),
        .nxt (lfsr_next)
    );

    lfsr_galois #(
        .W    (OUT_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .cur (sig),
        .din (cut.resp_in),
        .nxt (misr_next)
    );

    assign cut.vec_out   = lfsr_q;
    assign cut.vec_valid = vec_valid_q;

    // Run sequencer: start from IDLE/DONE reloads the generator, each ack
    // in DRIVE advances LFSR, MISR and count; the last ack latches pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lfsr_q      <= SEED_EFF;
            sig         <= '0;
            count       <= '0;
            vec_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= DRIVE;
                        lfsr_q      <= SEED_EFF;
                        sig         <= '0;
                        count       <= '0;
                        vec_valid_q <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cut.resp_valid) begin
                        lfsr_q <= lfsr_next;
                        sig    <= misr_next;
                        count  <= count + CNT_W'(1);
                        if (count == LAST) begin
                            state       <= DONE;
                            vec_valid_q <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            pass        <= (misr_next == golden_sig);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
